// File: rtl/ni_ctrl_fsm.sv
// ----------------------------------------------------------------------------
// ni_ctrl_fsm
//
// Sequential processor-to-NoC network-interface controller for the MIPS
// decode stage. It handles the ni_out / ni_in instructions with two engines:
//
//   TX engine : holds one outgoing flit (dest + payload) until the NI takes
//               it (proc_valid && mips_ni on a rising edge). If the NI does
//               not take it within TX_TIMEOUT wait cycles, the flit is
//               dropped and the sticky tx_err flag is raised.
//   RX engine : buffers incoming flits in an RX_DEPTH-entry FIFO and hands
//               the head entry to the register file (reg_en / rx_data) when
//               an ni_in instruction is issued.
//
// stall_D holds decode/fetch while an ni_out finds the TX engine busy or an
// ni_in finds the RX FIFO empty.
//
// Ports
//   clk            in   clock, all state updates on the rising edge
//   rst            in   synchronous reset, active-high
//   opcode_D       in   decode-stage opcode
//   issue_D        in   decode instruction valid (not bubble / flushed)
//   dest_D         in   destination node for ni_out
//   src_data_D     in   payload for ni_out
//   stall_D        out  hold decode/fetch this cycle
//   mips_ni        in   NI can accept the outgoing flit
//   proc_valid     out  outgoing flit valid
//   proc_dest      out  outgoing destination
//   proc_data      out  outgoing payload
//   data_valid     in   incoming flit valid
//   ni_data        in   incoming payload
//   proc_ready_in  out  FIFO can accept the incoming flit
//   reg_en         out  one-cycle write strobe for rx_data
//   rx_data        out  payload popped by the last ni_in
//   rx_count       out  FIFO occupancy
//   tx_err         out  sticky TX timeout flag
//   err_clr        in   clears tx_err
// ----------------------------------------------------------------------------
module ni_ctrl_fsm #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned DEST_W     = 2,
    parameter int unsigned RX_DEPTH   = 4,
    parameter int unsigned TX_TIMEOUT = 255,
    parameter logic [5:0]  OP_NI_OUT  = 6'b010101,
    parameter logic [5:0]  OP_NI_IN   = 6'b011010
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [5:0]                        opcode_D,
    input  logic                              issue_D,
    input  logic [DEST_W-1:0]                 dest_D,
    input  logic [DATA_W-1:0]                 src_data_D,
    output logic                              stall_D,
    input  logic                              mips_ni,
    output logic                              proc_valid,
    output logic [DEST_W-1:0]                 proc_dest,
    output logic [DATA_W-1:0]                 proc_data,
    input  logic                              data_valid,
    input  logic [DATA_W-1:0]                 ni_data,
    output logic                              proc_ready_in,
    output logic                              reg_en,
    output logic [DATA_W-1:0]                 rx_data,
    output logic [$clog2(RX_DEPTH+1)-1:0]     rx_count,
    output logic                              tx_err,
    input  logic                              err_clr
);

    localparam int unsigned CNT_W = $clog2(RX_DEPTH + 1);
    localparam int unsigned PTR_W = $clog2(RX_DEPTH);
    localparam int unsigned TMO_W = $clog2(TX_TIMEOUT + 1);

    // Last wait-cycle count before the flit is abandoned. The counter starts
    // at 0 in the first TX_WAIT cycle, so TX_TIMEOUT wait cycles elapse.
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TX_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RX_DEPTH);

    typedef enum logic [0:0] {
        TX_IDLE = 1'b0,
        TX_WAIT = 1'b1
    } tx_state_t;

    // ------------------------------------------------------------------------
    // Instruction decode
    // ------------------------------------------------------------------------
    logic w_ni_out;
    logic w_ni_in;

    assign w_ni_out = issue_D && (opcode_D == OP_NI_OUT);
    assign w_ni_in  = issue_D && (opcode_D == OP_NI_IN);

    // ------------------------------------------------------------------------
    // TX engine
    // ------------------------------------------------------------------------
    tx_state_t          r_tx_state;
    tx_state_t          w_tx_state_nxt;
    logic [DEST_W-1:0]  r_tx_dest;
    logic [DATA_W-1:0]  r_tx_data;
    logic [TMO_W-1:0]   r_tx_tmo;
    logic               r_tx_err;

    logic w_tx_load;
    logic w_tx_accept;
    logic w_tx_timeout;

    assign w_tx_load    = (r_tx_state == TX_IDLE) && w_ni_out;
    assign w_tx_accept  = (r_tx_state == TX_WAIT) && mips_ni;
    // Acceptance is checked first, so a transfer on the final wait cycle
    // completes normally instead of raising an error.
    assign w_tx_timeout = (r_tx_state == TX_WAIT) && !mips_ni && (r_tx_tmo == TMO_LAST);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_state <= TX_IDLE;
        end else begin
            r_tx_state <= w_tx_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_tx_state_nxt = r_tx_state;
        unique case (r_tx_state)
            TX_IDLE: begin
                if (w_ni_out) begin
                    w_tx_state_nxt = TX_WAIT;
                end
            end
            TX_WAIT: begin
                if (w_tx_accept || w_tx_timeout) begin
                    w_tx_state_nxt = TX_IDLE;
                end
            end
            default: w_tx_state_nxt = TX_IDLE;
        endcase
    end

    // Flit holding register, wait counter and sticky error flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_dest <= '0;
            r_tx_data <= '0;
            r_tx_tmo  <= '0;
            r_tx_err  <= 1'b0;
        end else begin
            if (w_tx_load) begin
                r_tx_dest <= dest_D;
                r_tx_data <= src_data_D;
                r_tx_tmo  <= '0;
            end else if ((r_tx_state == TX_WAIT) && !mips_ni && !w_tx_timeout) begin
                r_tx_tmo <= r_tx_tmo + TMO_W'(1);
            end

            // A timeout in the same cycle as err_clr leaves the flag set.
            if (w_tx_timeout) begin
                r_tx_err <= 1'b1;
            end else if (err_clr) begin
                r_tx_err <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // RX FIFO
    // ------------------------------------------------------------------------
    logic [DATA_W-1:0] r_rx_mem [RX_DEPTH];
    logic [PTR_W-1:0]  r_rx_wptr;
    logic [PTR_W-1:0]  r_rx_rptr;
    logic [CNT_W-1:0]  r_rx_count;
    logic              r_reg_en;
    logic [DATA_W-1:0] r_rx_data;

    logic w_rx_full;
    logic w_rx_empty;
    logic w_rx_push;
    logic w_rx_pop;

    assign w_rx_full  = (r_rx_count == CNT_FULL);
    assign w_rx_empty = (r_rx_count == '0);
    // Readiness comes from the registered count only: a pop in the same cycle
    // does not open room for a push while full, and a push into an empty FIFO
    // is not visible to ni_in until the following cycle.
    assign w_rx_push  = data_valid && !w_rx_full;
    assign w_rx_pop   = w_ni_in && !w_rx_empty;

    // Storage array needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        if (w_rx_push) begin
            r_rx_mem[r_rx_wptr] <= ni_data;
        end
    end

    // Pointers rely on RX_DEPTH being a power of two to wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_wptr  <= '0;
            r_rx_rptr  <= '0;
            r_rx_count <= '0;
            r_reg_en   <= 1'b0;
            r_rx_data  <= '0;
        end else begin
            if (w_rx_push) begin
                r_rx_wptr <= r_rx_wptr + PTR_W'(1);
            end
            if (w_rx_pop) begin
                r_rx_rptr <= r_rx_rptr + PTR_W'(1);
                r_rx_data <= r_rx_mem[r_rx_rptr];
            end
            r_reg_en <= w_rx_pop;

            unique case ({w_rx_push, w_rx_pop})
                2'b10:   r_rx_count <= r_rx_count + CNT_W'(1);
                2'b01:   r_rx_count <= r_rx_count - CNT_W'(1);
                default: r_rx_count <= r_rx_count;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------------
    always_comb begin
        proc_valid    = (r_tx_state == TX_WAIT);
        proc_dest     = r_tx_dest;
        proc_data     = r_tx_data;
        tx_err        = r_tx_err;
        proc_ready_in = !w_rx_full;
        reg_en        = r_reg_en;
        rx_data       = r_rx_data;
        rx_count      = r_rx_count;
        stall_D       = (w_ni_out && (r_tx_state == TX_WAIT)) ||
                        (w_ni_in && w_rx_empty);
    end

endmodule

// File: tb/tb_ni_ctrl_fsm.sv
// ----------------------------------------------------------------------------
// tb_ni_ctrl_fsm
//
// Directed bench for ni_ctrl_fsm with RX_DEPTH=4 and TX_TIMEOUT=4. Inputs are
// driven 1 time unit after the rising edge; outputs are checked shortly after
// the inputs settle, well away from the next rising edge.
// ----------------------------------------------------------------------------
module tb_ni_ctrl_fsm;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned DEST_W     = 2;
    localparam int unsigned RX_DEPTH   = 4;
    localparam int unsigned TX_TIMEOUT = 4;
    localparam logic [5:0]  OP_OUT     = 6'b010101;
    localparam logic [5:0]  OP_IN      = 6'b011010;

    logic              clk = 1'b0;
    logic              rst;
    logic [5:0]        opcode_D;
    logic              issue_D;
    logic [DEST_W-1:0] dest_D;
    logic [DATA_W-1:0] src_data_D;
    logic              stall_D;
    logic              mips_ni;
    logic              proc_valid;
    logic [DEST_W-1:0] proc_dest;
    logic [DATA_W-1:0] proc_data;
    logic              data_valid;
    logic [DATA_W-1:0] ni_data;
    logic              proc_ready_in;
    logic              reg_en;
    logic [DATA_W-1:0] rx_data;
    logic [2:0]        rx_count;
    logic              tx_err;
    logic              err_clr;

    int unsigned n_checks = 0;
    int unsigned n_err    = 0;

    ni_ctrl_fsm #(
        .DATA_W     (DATA_W),
        .DEST_W     (DEST_W),
        .RX_DEPTH   (RX_DEPTH),
        .TX_TIMEOUT (TX_TIMEOUT),
        .OP_NI_OUT  (OP_OUT),
        .OP_NI_IN   (OP_IN)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .opcode_D      (opcode_D),
        .issue_D       (issue_D),
        .dest_D        (dest_D),
        .src_data_D    (src_data_D),
        .stall_D       (stall_D),
        .mips_ni       (mips_ni),
        .proc_valid    (proc_valid),
        .proc_dest     (proc_dest),
        .proc_data     (proc_data),
        .data_valid    (data_valid),
        .ni_data       (ni_data),
        .proc_ready_in (proc_ready_in),
        .reg_en        (reg_en),
        .rx_data       (rx_data),
        .rx_count      (rx_count),
        .tx_err        (tx_err),
        .err_clr       (err_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst        = 1'b1;
        opcode_D   = '0;
        issue_D    = 1'b0;
        dest_D     = '0;
        src_data_D = '0;
        mips_ni    = 1'b0;
        data_valid = 1'b0;
        ni_data    = '0;
        err_clr    = 1'b0;

        // ---------------- reset state ----------------
        tick();
        tick();
        #1;
        chk("rst_pv",    32'(proc_valid),    32'd0);
        chk("rst_dest",  32'(proc_dest),     32'd0);
        chk("rst_data",  proc_data,          32'd0);
        chk("rst_stall", 32'(stall_D),       32'd0);
        chk("rst_ready", 32'(proc_ready_in), 32'd1);
        chk("rst_regen", 32'(reg_en),        32'd0);
        chk("rst_rxd",   rx_data,            32'd0);
        chk("rst_cnt",   32'(rx_count),      32'd0);
        chk("rst_err",   32'(tx_err),        32'd0);
        rst = 1'b0;
        tick();

        // ---------------- TX transfer after 3 wait cycles ----------------
        opcode_D   = OP_OUT;
        issue_D    = 1'b1;
        dest_D     = 2'b10;
        src_data_D = 32'hDEADBEEF;
        #1;
        chk("tx_issue_stall", 32'(stall_D),    32'd0);
        chk("tx_issue_pv",    32'(proc_valid), 32'd0);
        tick();
        // Second ni_out held in decode while the first one waits.
        dest_D     = 2'b01;
        src_data_D = 32'h12345678;
        for (int i = 0; i < 4; i++) begin
            mips_ni = (i == 3);
            #1;
            chk("tx_wait_pv",    32'(proc_valid), 32'd1);
            chk("tx_wait_dest",  32'(proc_dest),  32'd2);
            chk("tx_wait_data",  proc_data,       32'hDEADBEEF);
            chk("tx_wait_stall", 32'(stall_D),    32'd1);
            tick();
        end
        mips_ni = 1'b0;
        #1;
        chk("tx_after_pv",    32'(proc_valid), 32'd0);
        chk("tx_after_stall", 32'(stall_D),    32'd0);
        chk("tx_after_err",   32'(tx_err),     32'd0);
        tick();
        issue_D = 1'b0;
        #1;
        chk("tx2_pv",   32'(proc_valid), 32'd1);
        chk("tx2_dest", 32'(proc_dest),  32'd1);
        chk("tx2_data", proc_data,       32'h12345678);
        mips_ni = 1'b1;
        tick();
        mips_ni = 1'b0;
        #1;
        chk("tx2_done_pv", 32'(proc_valid), 32'd0);
        tick();

        // ---------------- TX timeout ----------------
        opcode_D   = OP_OUT;
        issue_D    = 1'b1;
        dest_D     = 2'b11;
        src_data_D = 32'hA5A5A5A5;
        tick();
        issue_D = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("tmo_wait_pv", 32'(proc_valid), 32'd1);
            tick();
        end
        #1;
        chk("tmo_pv",  32'(proc_valid), 32'd0);
        chk("tmo_err", 32'(tx_err),     32'd1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        #1;
        chk("errclr", 32'(tx_err), 32'd0);
        // err_clr held across a second timeout: the timeout wins.
        issue_D = 1'b1;
        tick();
        issue_D = 1'b0;
        err_clr = 1'b1;
        repeat (4) tick();
        err_clr = 1'b0;
        #1;
        chk("tmo_clr_err", 32'(tx_err),     32'd1);
        chk("tmo_clr_pv",  32'(proc_valid), 32'd0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        #1;
        chk("errclr2", 32'(tx_err), 32'd0);
        tick();

        // ---------------- RX fill to full ----------------
        opcode_D = '0;
        for (int k = 1; k <= 4; k++) begin
            data_valid = 1'b1;
            ni_data    = 32'(k);
            #1;
            chk("fill_ready", 32'(proc_ready_in), 32'd1);
            tick();
        end
        ni_data = 32'd5;
        #1;
        chk("full_ready", 32'(proc_ready_in), 32'd0);
        chk("full_cnt",   32'(rx_count),      32'd4);
        tick();
        chk("full_nopush_cnt", 32'(rx_count), 32'd4);

        // Drain in order; the first pop coincides with a held flit while full.
        opcode_D = OP_IN;
        issue_D  = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            #1;
            chk("pop_stall", 32'(stall_D), 32'd0);
            tick();
            data_valid = 1'b0;
            chk("pop_regen", 32'(reg_en),   32'd1);
            chk("pop_data",  rx_data,       32'(k));
            chk("pop_cnt",   32'(rx_count), 32'(4 - k));
        end
        issue_D = 1'b0;
        tick();
        chk("drain_regen", 32'(reg_en),        32'd0);
        chk("drain_ready", 32'(proc_ready_in), 32'd1);

        // ---------------- wrap with simultaneous push/pop ----------------
        for (int v = 10; v <= 12; v++) begin
            data_valid = 1'b1;
            ni_data    = 32'(v);
            tick();
        end
        issue_D = 1'b1;
        ni_data = 32'd13;
        #1;
        chk("pp_stall", 32'(stall_D), 32'd0);
        tick();
        chk("pp1_cnt",   32'(rx_count), 32'd3);
        chk("pp1_regen", 32'(reg_en),   32'd1);
        chk("pp1_data",  rx_data,       32'd10);
        ni_data = 32'd14;
        tick();
        chk("pp2_cnt",  32'(rx_count), 32'd3);
        chk("pp2_data", rx_data,       32'd11);
        data_valid = 1'b0;
        for (int e = 12; e <= 14; e++) begin
            tick();
            chk("wrap_data", rx_data,       32'(e));
            chk("wrap_cnt",  32'(rx_count), 32'(14 - e));
        end
        issue_D = 1'b0;
        tick();
        chk("wrap_regen", 32'(reg_en), 32'd0);

        // ---------------- ni_in on empty FIFO ----------------
        opcode_D = OP_IN;
        issue_D  = 1'b0;
        #1;
        chk("noissue_stall", 32'(stall_D), 32'd0);
        opcode_D = 6'h00;
        issue_D  = 1'b1;
        #1;
        chk("otherop_stall", 32'(stall_D), 32'd0);
        opcode_D = OP_IN;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("empty_stall", 32'(stall_D), 32'd1);
            tick();
            chk("empty_regen", 32'(reg_en), 32'd0);
        end
        data_valid = 1'b1;
        ni_data    = 32'h55;
        #1;
        chk("nobypass_stall", 32'(stall_D), 32'd1);
        tick();
        data_valid = 1'b0;
        #1;
        chk("late_cnt",   32'(rx_count), 32'd1);
        chk("late_stall", 32'(stall_D),  32'd0);
        chk("late_regen", 32'(reg_en),   32'd0);
        tick();
        issue_D = 1'b0;
        #1;
        chk("late_pop_regen", 32'(reg_en),   32'd1);
        chk("late_pop_data",  rx_data,       32'h55);
        chk("late_pop_cnt",   32'(rx_count), 32'd0);
        tick();
        chk("late_pulse_end", 32'(reg_en), 32'd0);

        // ---------------- reset mid-operation ----------------
        opcode_D = '0;
        for (int v = 7; v <= 8; v++) begin
            data_valid = 1'b1;
            ni_data    = 32'(v);
            tick();
        end
        data_valid = 1'b0;
        opcode_D   = OP_OUT;
        issue_D    = 1'b1;
        dest_D     = 2'b01;
        src_data_D = 32'h0000CAFE;
        tick();
        issue_D = 1'b0;
        repeat (4) tick();
        issue_D = 1'b1;
        tick();
        opcode_D = 6'h00;
        #1;
        chk("pre_rst_otherop_stall", 32'(stall_D),    32'd0);
        chk("pre_rst_pv",            32'(proc_valid), 32'd1);
        chk("pre_rst_cnt",           32'(rx_count),   32'd2);
        chk("pre_rst_err",           32'(tx_err),     32'd1);
        issue_D = 1'b0;
        rst     = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("mid_rst_pv",    32'(proc_valid),    32'd0);
        chk("mid_rst_cnt",   32'(rx_count),      32'd0);
        chk("mid_rst_err",   32'(tx_err),        32'd0);
        chk("mid_rst_ready", 32'(proc_ready_in), 32'd1);
        chk("mid_rst_data",  proc_data,          32'd0);
        opcode_D = OP_IN;
        issue_D  = 1'b1;
        #1;
        chk("mid_rst_empty_stall", 32'(stall_D), 32'd1);
        tick();
        issue_D = 1'b0;
        chk("mid_rst_idle_pv", 32'(proc_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/ni_ctrl_fsm.md
Name: ni_ctrl_fsm

Overview:
Sequential processor-to-NoC network-interface controller for the MIPS decode stage. It replaces combinational ni_out/ni_in decoding with two engines:
- a TX engine holding one outgoing flit until the NI accepts it, with timeout and error flag;
- an RX engine buffering incoming flits in a RX_DEPTH FIFO and delivering them to the register file on ni_in.
It generates stall_D toward the pipeline hazard logic.

Parameters:
DATA_W, 32, flit payload width
DEST_W, 2, destination node address width
RX_DEPTH, 4, RX FIFO entries (power of 2, >=2)
TX_TIMEOUT, 255, cycles TX may wait for mips_ni before abort (>=1)
OP_NI_OUT, 6'b010101, ni_out opcode
OP_NI_IN, 6'b011010, ni_in opcode

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous reset, active-high
opcode_D  in  6  decode-stage opcode
issue_D  in  1  decode instruction valid (not bubble/flushed)
dest_D  in  DEST_W  destination address for ni_out
src_data_D  in  DATA_W  operand to send for ni_out
stall_D  out  1  hold decode/fetch this cycle
mips_ni  in  1  NI can accept flit
proc_valid  out  1  outgoing flit valid
proc_dest  out  DEST_W  outgoing destination
proc_data  out  DATA_W  outgoing payload
data_valid  in  1  incoming flit valid
ni_data  in  DATA_W  incoming payload
proc_ready_in  out  1  controller can accept incoming flit
reg_en  out  1  write rx_data to register file
rx_data  out  DATA_W  popped payload
rx_count  out  clog2(RX_DEPTH+1)  FIFO occupancy
tx_err  out  1  sticky TX timeout flag
err_clr  in  1  clears tx_err

Behaviour:
- Reset (rst=1 at posedge):
  - TX state=TX_IDLE; proc_valid=0, proc_dest=0, proc_data=0, timeout counter=0, tx_err=0.
  - FIFO pointers/count=0; reg_en=0, rx_data=0.
  - Mid-operation reset drops any held or buffered flit.
- TX FSM, states TX_IDLE and TX_WAIT:
  - TX_IDLE with issue_D and opcode_D==OP_NI_OUT: latch dest_D/src_data_D, go TX_WAIT. proc_valid=1 from the next cycle (1-cycle latency). stall_D=0.
  - TX_WAIT: proc_valid/proc_dest/proc_data are held stable. Transfer occurs on a posedge with proc_valid&&mips_ni, then return to TX_IDLE.
  - TX_WAIT with another issued ni_out: stall_D=1 until the cycle after transfer.
  - Counter increments each TX_WAIT cycle without mips_ni. Reaching TX_TIMEOUT: drop the flit, proc_valid=0, tx_err=1, go TX_IDLE.
  - Transfer and timeout in the same cycle: transfer wins, no error.
  - err_clr clears tx_err. If err_clr and a timeout occur in the same cycle, tx_err=1.
- RX FIFO:
  - proc_ready_in = (rx_count != RX_DEPTH), combinational from registered count.
  - Push on posedge when data_valid&&proc_ready_in.
  - Full: no push even if a pop occurs in the same cycle. The NI must hold the flit.
- ni_in (issue_D && opcode_D==OP_NI_IN):
  - Non-empty: pop on that posedge; reg_en=1 and rx_data=head the next cycle, for exactly 1 cycle.
  - Empty: stall_D=1, no pop. Pop occurs the cycle after the first push lands (count>0).
  - Simultaneous push+pop when not full and not empty: count unchanged, FIFO order preserved.
  - Push into empty plus ni_in the same cycle: no bypass; stall this cycle, pop next cycle.
- Pointers wrap modulo RX_DEPTH; rx_count is never >RX_DEPTH and never <0.
- Other opcodes: no effect; stall_D=0 from this block.
- stall_D = (ni_out issued && TX_WAIT) || (ni_in issued && rx_count==0).

Test Plan:
- Reset then idle -> all outputs 0 except proc_ready_in=1; rx_count=0.
- ni_out dest=2'b10 data=32'hDEADBEEF, mips_ni=0 for 3 cycles then 1:
  - proc_valid high 4 cycles, values stable, drops after accept.
  - A second ni_out issued during the wait sees stall_D=1 until the cycle after transfer.
- mips_ni held 0, TX_TIMEOUT=4:
  - proc_valid falls after 4 wait cycles, tx_err=1.
  - err_clr pulse gives tx_err=0.
- Push 4 flits 1..4 (RX_DEPTH=4):
  - proc_ready_in=0, rx_count=4; a 5th data_valid is not accepted.
  - 4 ni_in yield reg_en pulses with rx_data 1,2,3,4 in order; wrap checked with 3 more pushes/pops.
- ni_in with empty FIFO:
  - stall_D=1 for 3 cycles.
  - data_valid with 32'h55 arrives, and the next cycle pops: reg_en=1, rx_data=32'h55, stall_D=0.
- rst asserted while in TX_WAIT with 2 entries buffered -> next cycle proc_valid=0, rx_count=0, tx_err=0.
